// File: rtl/alu_ctrl.sv
// Purpose: sequencing controller for an external 8-bit ALU; owns the accumulator and flags.
// Latency: accept edge to done pulse is 2 cycles for single-step ops, N+1 for N-step shifts.
// Backpressure: op_ready only in IDLE; requests while busy are ignored. Macro ALU_CTRL_MULTISHIFT_EN enables multi-step shifts.
module alu_ctrl #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [2:0]       opcode,
   input  logic [7:0]       operand,
   input  logic [CNT_W-1:0] count,
   output logic [7:0]       alu_a,
   output logic [7:0]       alu_b,
   output logic [1:0]       alu_sel,
   output logic [1:0]       load_shift,
   input  logic [7:0]       alu_result,
   input  logic             alu_cout,
   input  logic             alu_zout,
   output logic [7:0]       acc,
   output logic             carry_flag,
   output logic             zero_flag,
   output logic             done
);

   localparam logic [2:0] OP_CLR = 3'b000;
   localparam logic [2:0] OP_LDA = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_NOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;

   localparam logic [1:0] SEL_LS  = 2'b00;
   localparam logic [1:0] SEL_NOR = 2'b01;
   localparam logic [1:0] SEL_ADD = 2'b10;
   localparam logic [1:0] SEL_SUB = 2'b11;

   localparam logic [1:0] LS_ZERO = 2'b00;
   localparam logic [1:0] LS_SHL  = 2'b01;
   localparam logic [1:0] LS_PASS = 2'b10;
   localparam logic [1:0] LS_SHR  = 2'b11;

`ifdef ALU_CTRL_MULTISHIFT_EN
   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd3} state_t;
`endif

   state_t     state;
   state_t     state_nxt;
   logic [2:0] op_q;
   logic [7:0] opnd_q;
   logic       capture;

`ifdef ALU_CTRL_MULTISHIFT_EN
   // cnt_q holds the latched count and then counts down the steps still to run
   logic [CNT_W-1:0] cnt_q;
   logic             is_shift;
   logic             shift_zero;

   assign is_shift = (op_q == OP_SHL) || (op_q == OP_SHR);
`else
   // every shift is a single step, so the requested count has no effect
   logic count_unused;

   assign count_unused = ^count;
`endif

   assign alu_b = opnd_q;

   // state register; reset returns to IDLE and aborts any operation in flight
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (op_valid) state_nxt = EXEC;
`ifdef ALU_CTRL_MULTISHIFT_EN
         EXEC: begin
            if (is_shift && (cnt_q > CNT_W'(1))) state_nxt = SHIFT;
            else                                 state_nxt = DONE;
         end
         SHIFT: if (cnt_q <= CNT_W'(1)) state_nxt = DONE;
`else
         EXEC: state_nxt = DONE;
`endif
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ALU drive codes and the capture strobe for each state/opcode
   always_comb begin
      op_ready   = rst_n && (state == IDLE);
      alu_a      = acc;
      alu_sel    = SEL_LS;
      load_shift = LS_PASS;
      capture    = 1'b0;
`ifdef ALU_CTRL_MULTISHIFT_EN
      shift_zero = 1'b0;
`endif
      case (state)
         EXEC: begin
            case (op_q)
               OP_CLR: begin load_shift = LS_ZERO; capture = 1'b1; end
               OP_LDA: begin alu_a = opnd_q; capture = 1'b1; end
               OP_ADD: begin alu_sel = SEL_ADD; capture = 1'b1; end
               OP_SUB: begin alu_sel = SEL_SUB; capture = 1'b1; end
               OP_NOR: begin alu_sel = SEL_NOR; capture = 1'b1; end
               OP_SHL, OP_SHR: begin
                  load_shift = (op_q == OP_SHL) ? LS_SHL : LS_SHR;
`ifdef ALU_CTRL_MULTISHIFT_EN
                  capture    = (cnt_q != '0);
                  shift_zero = (cnt_q == '0);
`else
                  capture    = 1'b1;
`endif
               end
               default: ;
            endcase
         end
`ifdef ALU_CTRL_MULTISHIFT_EN
         SHIFT: begin
            load_shift = (op_q == OP_SHL) ? LS_SHL : LS_SHR;
            capture    = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // request latches, accumulator/flag capture and the registered done pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc        <= 8'h00;
         carry_flag <= 1'b0;
         zero_flag  <= 1'b1;
         done       <= 1'b0;
         op_q       <= 3'b000;
         opnd_q     <= 8'h00;
`ifdef ALU_CTRL_MULTISHIFT_EN
         cnt_q      <= '0;
`endif
      end else begin
         done <= (state == DONE);
         if (op_valid && op_ready) begin
            op_q   <= opcode;
            opnd_q <= operand;
`ifdef ALU_CTRL_MULTISHIFT_EN
            cnt_q  <= count;
`endif
         end
         if (capture) begin
            acc        <= alu_result;
            carry_flag <= alu_cout;
            zero_flag  <= alu_zout;
         end
`ifdef ALU_CTRL_MULTISHIFT_EN
         // a zero-length shift leaves acc alone but still defines the flags
         if (shift_zero) begin
            carry_flag <= 1'b0;
            zero_flag  <= (acc == 8'h00);
         end
         // counter stops at zero so it can never wrap
         if (((state == EXEC) || (state == SHIFT)) && is_shift && (cnt_q != '0))
            cnt_q <= cnt_q - CNT_W'(1);
`endif
      end
   end

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: behavioural ALU on the return path, vector table plus scoreboard on done.
// Expected results are queued at accept and checked (acc, flags, latency) when done pulses.
// Shift expectations follow ALU_CTRL_MULTISHIFT_EN.
`timescale 1ns/1ps
module tb_alu_ctrl;
   localparam int CNT_W = 3;

   localparam logic [2:0] OP_CLR = 3'b000;
   localparam logic [2:0] OP_LDA = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_NOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_NOP = 3'b111;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             op_valid = 1'b0;
   logic             op_ready;
   logic [2:0]       opcode = 3'b000;
   logic [7:0]       operand = 8'h00;
   logic [CNT_W-1:0] count = '0;
   logic [7:0]       alu_a, alu_b, alu_result, acc;
   logic [1:0]       alu_sel, load_shift;
   logic             alu_cout, alu_zout, carry_flag, zero_flag, done;
   logic [8:0]       alu_t;

   always #5 clk = ~clk;

   alu_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
      .opcode(opcode), .operand(operand), .count(count),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .load_shift(load_shift),
      .alu_result(alu_result), .alu_cout(alu_cout), .alu_zout(alu_zout),
      .acc(acc), .carry_flag(carry_flag), .zero_flag(zero_flag), .done(done)
   );

   // reference ALU: 9-bit add/sub (bit 8 is carry/borrow), nor, load/shift
   always_comb begin
      alu_t = '0;
      case (alu_sel)
         2'b10: alu_t = {1'b0, alu_a} + {1'b0, alu_b};
         2'b11: alu_t = {1'b0, alu_a} - {1'b0, alu_b};
         2'b01: alu_t = {1'b0, ~(alu_a | alu_b)};
         default: begin
            case (load_shift)
               2'b10:   alu_t = {1'b0, alu_a};
               2'b11:   alu_t = {alu_a[0], 1'b0, alu_a[7:1]};
               2'b01:   alu_t = {alu_a, 1'b0};
               default: alu_t = '0;
            endcase
         end
      endcase
   end
   assign alu_result = alu_t[7:0];
   assign alu_cout   = alu_t[8];
   assign alu_zout   = (alu_t[7:0] == 8'h00);

   typedef struct {
      logic [2:0]       opc;
      logic [7:0]       opnd;
      logic [CNT_W-1:0] cnt;
      logic [7:0]       acc;
      logic             c;
      logic             z;
      int               lat;
      string            name;
   } vec_t;

   typedef struct {
      logic [7:0] acc;
      logic       c;
      logic       z;
      int         lat;
      int         acc_cyc;
      string      name;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   n_acc = 0;

   // cycle counter and accept counter, both updated on the active edge
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (op_valid && op_ready) n_acc <= n_acc + 1;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] opc, input logic [7:0] opnd,
                               input logic [CNT_W-1:0] cnt, input logic [7:0] a,
                               input logic c, input logic z, input int lat, input string nm);
      vec_t v;
      v.opc = opc; v.opnd = opnd; v.cnt = cnt; v.acc = a; v.c = c; v.z = z;
      v.lat = lat; v.name = nm;
      return v;
   endfunction

   // scoreboard: every done pulse must match the oldest outstanding request
   always @(negedge clk) begin : mon
      exp_t e;
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: actual done=1 required no pulse at cycle %0d", cyc);
         end else begin
            e = sb.pop_front();
            check({e.name, ".acc"}, 32'(acc), 32'(e.acc));
            check({e.name, ".carry"}, 32'(carry_flag), 32'(e.c));
            check({e.name, ".zero"}, 32'(zero_flag), 32'(e.z));
            check({e.name, ".latency"}, 32'(cyc - e.acc_cyc), 32'(e.lat));
         end
      end
   end

   // present a request at a negedge, wait (bounded) for ready, queue the expectation
   task automatic present(input vec_t v, input bit drop);
      exp_t e;
      op_valid = 1'b1; opcode = v.opc; operand = v.opnd; count = v.cnt;
      for (int i = 0; i < 40 && !op_ready; i++) @(negedge clk);
      if (!op_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s.accept_timeout: actual op_ready=0 required 1", v.name);
         op_valid = 1'b0;
      end else begin
         e.acc = v.acc; e.c = v.c; e.z = v.z; e.lat = v.lat;
         e.acc_cyc = cyc + 1; e.name = v.name;
         sb.push_back(e);
         @(negedge clk);
         if (drop) op_valid = 1'b0;
      end
   endtask

   task automatic wait_idle(input string nm);
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s.done_timeout: actual pending=%0d required 0", nm, sb.size());
         sb.delete();
      end
   endtask

   task automatic run_vec(input vec_t v);
      present(v, 1'b1);
      wait_idle(v.name);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int acc0;
      // reset with a request pending: it must not be accepted
      op_valid = 1'b1; opcode = OP_LDA; operand = 8'h55;
      repeat (3) @(negedge clk);
      check("rst.op_ready_low", 32'(op_ready), 32'd0);
      rst_n = 1'b1; op_valid = 1'b0;
      #1 check("rst.op_ready_release", 32'(op_ready), 32'd1);
      @(negedge clk);
      check("rst.acc", 32'(acc), 32'h00);
      check("rst.carry", 32'(carry_flag), 32'd0);
      check("rst.zero", 32'(zero_flag), 32'd1);
      check("rst.done", 32'(done), 32'd0);
      check("rst.alu_sel", 32'(alu_sel), 32'd0);
      check("rst.load_shift", 32'(load_shift), 32'd2);
      check("rst.alu_b", 32'(alu_b), 32'h00);

      vecs.push_back(mk(OP_CLR, 8'h00, 3'd0, 8'h00, 1'b0, 1'b1, 2, "clr0"));
      vecs.push_back(mk(OP_LDA, 8'hF0, 3'd0, 8'hF0, 1'b0, 1'b0, 2, "lda_f0"));
      vecs.push_back(mk(OP_ADD, 8'h20, 3'd0, 8'h10, 1'b1, 1'b0, 2, "add_20"));
      vecs.push_back(mk(OP_LDA, 8'h05, 3'd0, 8'h05, 1'b0, 1'b0, 2, "lda_05"));
      vecs.push_back(mk(OP_SUB, 8'h07, 3'd0, 8'hFE, 1'b1, 1'b0, 2, "sub_07"));
      vecs.push_back(mk(OP_SUB, 8'hFE, 3'd0, 8'h00, 1'b0, 1'b1, 2, "sub_fe"));
      vecs.push_back(mk(OP_LDA, 8'h0F, 3'd0, 8'h0F, 1'b0, 1'b0, 2, "lda_0f"));
      vecs.push_back(mk(OP_NOR, 8'hF0, 3'd0, 8'h00, 1'b0, 1'b1, 2, "nor_f0"));
      vecs.push_back(mk(OP_NOR, 8'h00, 3'd0, 8'hFF, 1'b0, 1'b0, 2, "nor_00"));
      vecs.push_back(mk(OP_LDA, 8'h81, 3'd0, 8'h81, 1'b0, 1'b0, 2, "lda_81"));
`ifdef ALU_CTRL_MULTISHIFT_EN
      vecs.push_back(mk(OP_SHL, 8'h00, 3'd3, 8'h08, 1'b0, 1'b0, 4, "shl_3"));
      vecs.push_back(mk(OP_NOP, 8'hAA, 3'd0, 8'h08, 1'b0, 1'b0, 2, "nop"));
      vecs.push_back(mk(OP_SHR, 8'h00, 3'd1, 8'h04, 1'b0, 1'b0, 2, "shr_1"));
      vecs.push_back(mk(OP_SHR, 8'h00, 3'd0, 8'h04, 1'b0, 1'b0, 2, "shr_0"));
      vecs.push_back(mk(OP_LDA, 8'h80, 3'd0, 8'h80, 1'b0, 1'b0, 2, "lda_80"));
      vecs.push_back(mk(OP_SHL, 8'h00, 3'd7, 8'h00, 1'b0, 1'b1, 8, "shl_7"));
`else
      vecs.push_back(mk(OP_SHL, 8'h00, 3'd3, 8'h02, 1'b1, 1'b0, 2, "shl_3"));
      vecs.push_back(mk(OP_NOP, 8'hAA, 3'd0, 8'h02, 1'b1, 1'b0, 2, "nop"));
      vecs.push_back(mk(OP_SHR, 8'h00, 3'd1, 8'h01, 1'b0, 1'b0, 2, "shr_1"));
      vecs.push_back(mk(OP_SHR, 8'h00, 3'd0, 8'h00, 1'b1, 1'b1, 2, "shr_0"));
      vecs.push_back(mk(OP_LDA, 8'h80, 3'd0, 8'h80, 1'b0, 1'b0, 2, "lda_80"));
      vecs.push_back(mk(OP_SHL, 8'h00, 3'd7, 8'h00, 1'b1, 1'b1, 2, "shl_7"));
`endif
      vecs.push_back(mk(OP_ADD, 8'hFF, 3'd0, 8'hFF, 1'b0, 1'b0, 2, "add_ff"));
      vecs.push_back(mk(OP_ADD, 8'h01, 3'd0, 8'h00, 1'b1, 1'b1, 2, "add_wrap"));
      vecs.push_back(mk(OP_SUB, 8'h01, 3'd0, 8'hFF, 1'b1, 1'b0, 2, "sub_borrow"));
`ifdef ALU_CTRL_MULTISHIFT_EN
      vecs.push_back(mk(OP_SHR, 8'h00, 3'd2, 8'h3F, 1'b1, 1'b0, 3, "shr_2"));
      vecs.push_back(mk(OP_SHL, 8'h00, 3'd0, 8'h3F, 1'b0, 1'b0, 2, "shl_0"));
`else
      vecs.push_back(mk(OP_SHR, 8'h00, 3'd2, 8'h7F, 1'b1, 1'b0, 2, "shr_2"));
      vecs.push_back(mk(OP_SHL, 8'h00, 3'd0, 8'hFE, 1'b0, 1'b0, 2, "shl_0"));
`endif
      vecs.push_back(mk(OP_CLR, 8'h00, 3'd0, 8'h00, 1'b0, 1'b1, 2, "clr_end"));

      foreach (vecs[i]) run_vec(vecs[i]);

      // reset while a long right shift is in flight: no done, state cleared
      run_vec(mk(OP_LDA, 8'hFF, 3'd0, 8'hFF, 1'b0, 1'b0, 2, "lda_ff"));
      op_valid = 1'b1; opcode = OP_SHR; operand = 8'h00; count = 3'd7;
      for (int i = 0; i < 40 && !op_ready; i++) @(negedge clk);
      @(negedge clk);
      op_valid = 1'b0;
`ifdef ALU_CTRL_MULTISHIFT_EN
      repeat (3) @(negedge clk);
`else
      @(negedge clk);
`endif
      rst_n = 1'b0; op_valid = 1'b1; opcode = OP_ADD; operand = 8'h01;
      @(negedge clk);
      check("abort.op_ready_low", 32'(op_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; op_valid = 1'b0;
      #1 check("abort.op_ready_release", 32'(op_ready), 32'd1);
      @(negedge clk);
      check("abort.acc", 32'(acc), 32'h00);
      check("abort.zero", 32'(zero_flag), 32'd1);
      check("abort.carry", 32'(carry_flag), 32'd0);
      repeat (8) @(negedge clk);

      // ADD held valid across a busy shift is accepted exactly once
      run_vec(mk(OP_LDA, 8'h03, 3'd0, 8'h03, 1'b0, 1'b0, 2, "lda_03"));
      acc0 = n_acc;
`ifdef ALU_CTRL_MULTISHIFT_EN
      present(mk(OP_SHL, 8'h00, 3'd3, 8'h18, 1'b0, 1'b0, 4, "hold_shl"), 1'b0);
      present(mk(OP_ADD, 8'h01, 3'd0, 8'h19, 1'b0, 1'b0, 2, "hold_add"), 1'b1);
`else
      present(mk(OP_SHL, 8'h00, 3'd3, 8'h06, 1'b0, 1'b0, 2, "hold_shl"), 1'b0);
      present(mk(OP_ADD, 8'h01, 3'd0, 8'h07, 1'b0, 1'b0, 2, "hold_add"), 1'b1);
`endif
      wait_idle("hold");
      repeat (5) @(negedge clk);
      check("hold.accept_count", 32'(n_acc - acc0), 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
